// File: rtl/dbg_frame_capture.sv
// dbg_frame_capture: non-intrusive Avalon-ST debug snooper.
// Waits for a programmable trigger beat, then records up to DEPTH consecutive
// beats (data/sop/eop/empty) into a buffer that is browsed via a registered
// read port.
// Optional build macro: DBG_CAPTURE_TIMESTAMP_EN adds a free-running cycle
// counter, per-entry timestamps and the rd_ts read output.
module dbg_frame_capture #(
    parameter int DW    = 32,
    parameter int EW    = 2,
    parameter int DEPTH = 16,
    parameter int IW    = 17,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [EW-1:0] in_empty,
    input  logic          arm,
    input  logic          clear,
    input  logic          mode,
    input  logic [IW-1:0] sel,
    input  logic          stop_on_eop,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_sop,
    output logic          rd_eop,
    output logic [EW-1:0] rd_empty,
    output logic          rd_valid,
    output logic [1:0]    state,
    output logic [AW:0]   count,
    output logic          trig_hit
`ifdef DBG_CAPTURE_TIMESTAMP_EN
    ,output logic [31:0]  rd_ts
`endif
);

    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_ARMED   = 2'd1;
    localparam logic [1:0]    ST_CAPTURE = 2'd2;
    localparam logic [1:0]    ST_DONE    = 2'd3;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] CNT_MAX    = '1;

    logic [1:0]    r_state;
    logic [AW:0]   r_count;
    logic          r_trigHit;
    logic          r_armQ;
    logic          r_inFrame;
    logic [IW-1:0] r_idxReg;
    logic [IW-1:0] r_frame;
    logic [DEPTH-1:0] r_valid;

    logic [DW-1:0] r_memData  [DEPTH];
    logic          r_memSop   [DEPTH];
    logic          r_memEop   [DEPTH];
    logic [EW-1:0] r_memEmpty [DEPTH];

    logic          w_beat;
    logic          w_armEvent;
    logic [IW-1:0] w_idx;
    logic          w_trigIndex;
    logic          w_trigFrame;
    logic          w_trigger;
    logic          w_write;
    logic [AW-1:0] w_wrAddr;
    logic [AW:0]   w_countNext;
    logic          w_stop;

    assign w_beat      = in_valid & in_ready;
    assign w_armEvent  = arm & ~r_armQ;
    assign w_idx       = in_sop ? '0 : r_idxReg;
    // Beats before the first sop after arm cannot trigger in INDEX mode
    // because their index is not anchored to a frame yet.
    assign w_trigIndex = (r_inFrame | in_sop) && (w_idx == sel);
    assign w_trigFrame = in_sop && (r_frame == sel);
    assign w_trigger   = (r_state == ST_ARMED) && w_beat && (mode ? w_trigFrame : w_trigIndex);
    // Clear and arm both win over a beat arriving in the same cycle.
    assign w_write     = ~clear & ~w_armEvent &
                         (w_trigger | ((r_state == ST_CAPTURE) & w_beat));
    assign w_wrAddr    = (r_state == ST_CAPTURE) ? r_count[AW-1:0] : '0;
    assign w_countNext = (r_state == ST_CAPTURE) ? r_count + (AW+1)'(1) : (AW+1)'(1);
    assign w_stop      = (w_countNext == FULL_COUNT) || (stop_on_eop && in_eop);

    assign state    = r_state;
    assign count    = r_count;
    assign trig_hit = r_trigHit;

    // Capture control: arm edge detect, word/frame tracking and the state machine.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_trigHit <= 1'b0;
            r_armQ    <= 1'b0;
            r_inFrame <= 1'b0;
            r_idxReg  <= '0;
            r_frame   <= '0;
            r_valid   <= '0;
        end else begin
            r_armQ <= arm;
            if (clear) begin
                r_state   <= ST_IDLE;
                r_count   <= '0;
                r_trigHit <= 1'b0;
                r_valid   <= '0;
            end else if (w_armEvent) begin
                r_state   <= ST_ARMED;
                r_count   <= '0;
                r_trigHit <= 1'b0;
                r_valid   <= '0;
                r_inFrame <= 1'b0;
                r_idxReg  <= '0;
                r_frame   <= '0;
            end else begin
                if (w_beat) begin
                    r_idxReg <= (w_idx == CNT_MAX) ? CNT_MAX : w_idx + IW'(1);
                    if (in_sop) begin
                        r_inFrame <= 1'b1;
                        if (r_frame != CNT_MAX) begin
                            r_frame <= r_frame + IW'(1);
                        end
                    end
                end
                if (w_write) begin
                    r_valid[w_wrAddr] <= 1'b1;
                    r_count           <= w_countNext;
                    r_state           <= w_stop ? ST_DONE : ST_CAPTURE;
                    if (w_trigger) begin
                        r_trigHit <= 1'b1;
                    end
                end
            end
        end
    end

    // Capture buffer storage; contents survive clear and need no reset.
    always_ff @(posedge sys_clk) begin
        if (w_write) begin
            r_memData[w_wrAddr]  <= in_data;
            r_memSop[w_wrAddr]   <= in_sop;
            r_memEop[w_wrAddr]   <= in_eop;
            r_memEmpty[w_wrAddr] <= in_empty;
        end
    end

    // Registered read port; a same-cycle write is not forwarded.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_sop   <= 1'b0;
            rd_eop   <= 1'b0;
            rd_empty <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= r_memData[rd_addr];
            rd_sop   <= r_memSop[rd_addr];
            rd_eop   <= r_memEop[rd_addr];
            rd_empty <= r_memEmpty[rd_addr];
            rd_valid <= r_valid[rd_addr];
        end
    end

`ifdef DBG_CAPTURE_TIMESTAMP_EN
    logic [31:0] r_tsCounter;
    logic [31:0] r_memTs [DEPTH];

    // Free-running cycle counter, untouched by arm and clear.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tsCounter <= '0;
        end else begin
            r_tsCounter <= r_tsCounter + 32'd1;
        end
    end

    // Timestamp storage alongside each captured beat.
    always_ff @(posedge sys_clk) begin
        if (w_write) begin
            r_memTs[w_wrAddr] <= r_tsCounter;
        end
    end

    // Timestamp read output with the same latency as the other rd_* outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ts <= '0;
        end else begin
            rd_ts <= r_memTs[rd_addr];
        end
    end
`endif

endmodule
